// File: rtl/cell_2r_pkg.sv
// rtl/cell_2r_pkg.sv - shared POKEY cell constants and strobe-qualified update decode
package cell_2r_pkg;

  // Clear value used by every resettable POKEY cell unless overridden.
  localparam logic CELL_CLEAR_BIT = 1'b0;

  // Strobe naming shared across cell types: enn marks the phase-clock
  // falling edge, enp the rising edge.
  typedef enum logic {
    STROBE_ENN = 1'b0,
    STROBE_ENP = 1'b1
  } strobe_kind_e;

  typedef enum logic [1:0] {
    CELL_HOLD  = 2'd0,
    CELL_LOAD  = 2'd1,
    CELL_CLEAR = 2'd2
  } cell_action_e;

  // Clear beats load; a load needs both complementary strobes to agree,
  // mirroring the original two-phase latch. Disagreeing strobes hold.
  function automatic cell_action_e cell_decode(input logic strobe,
                                               input logic ld,
                                               input logic nld,
                                               input logic clr);
    cell_action_e act;
    act = CELL_HOLD;
    if (strobe) begin
      if (clr)
        act = CELL_CLEAR;
      else if (ld && !nld)
        act = CELL_LOAD;
    end
    return act;
  endfunction

endpackage

// File: rtl/cell_2r_if.sv
// rtl/cell_2r_if.sv - strobe, control and data bundle of a cell_2r storage cell
interface cell_2r_if #(
  parameter int WIDTH = 1
);
  logic             enn;
  logic [WIDTH-1:0] D;
  logic             Ld;
  logic             nLd;
  logic             R;
  logic [WIDTH-1:0] Q;

  modport master (
    output enn,
    output D,
    output Ld,
    output nLd,
    output R,
    input  Q
  );

  modport slave (
    input  enn,
    input  D,
    input  Ld,
    input  nLd,
    input  R,
    output Q
  );
endinterface

// File: rtl/cell_2r.sv
// rtl/cell_2r.sv - resettable POKEY storage cell, loads or clears on the enn strobe
module cell_2r
  import cell_2r_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{CELL_CLEAR_BIT}}
) (
  input  logic     clk,
  input  logic     reset_n,
  cell_2r_if.slave bus
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_nxt;
  cell_action_e     action;

  assign action = cell_decode(bus.enn, bus.Ld, bus.nLd, bus.R);

  always_comb begin
    state_nxt = state;
    unique case (action)
      CELL_CLEAR: state_nxt = RESET_VAL;
      CELL_LOAD:  state_nxt = bus.D;
      default:    state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= RESET_VAL;
    else
      state <= state_nxt;
  end

  // Output straight from the flops: no input reaches Q combinationally.
  assign bus.Q = state;

endmodule

// File: tb/tb_cell_2r.sv
// tb/tb_cell_2r.sv - table-driven self-checking bench for cell_2r (WIDTH 1 and 4)
module tb_cell_2r;

  logic clk;
  logic rst_n;

  cell_2r_if #(.WIDTH(1)) if1 ();
  cell_2r_if #(.WIDTH(4)) if4 ();

  cell_2r #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (if1.slave)
  );

  cell_2r #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (if4.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic       enn;
    logic [3:0] d;
    logic       ld;
    logic       nld;
    logic       r;
    logic [3:0] exp_q;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive1(input logic enn, input logic d, input logic ld, input logic nld, input logic r);
    if1.enn = enn; if1.D = d; if1.Ld = ld; if1.nLd = nld; if1.R = r;
  endtask

  task automatic drive4(input logic enn, input logic [3:0] d, input logic ld, input logic nld, input logic r);
    if4.enn = enn; if4.D = d; if4.Ld = ld; if4.nLd = nld; if4.R = r;
  endtask

  vec_t v1[$];
  vec_t v4[$];

  initial begin
    // Width-1 vectors, starting from Q=1.
    v1.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h1}); // D change, no strobe
    v1.push_back('{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h1}); // strobe, no load
    v1.push_back('{1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 4'h1}); // illegal Ld=nLd=1
    v1.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1}); // illegal Ld=nLd=0
    v1.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h1}); // valid load, no strobe
    v1.push_back('{1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0}); // load zero
    v1.push_back('{1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 4'h1}); // load one
    v1.push_back('{1'b0, 4'h1, 1'b0, 1'b1, 1'b1, 4'h1}); // R without strobe
    v1.push_back('{1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 4'h0}); // R beats load
    v1.push_back('{1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0}); // hold after clear
    v1.push_back('{1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 4'h1}); // reload
    v1.push_back('{1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0}); // clear
    v1.push_back('{1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 4'h0}); // stays clear
    // Width-4 vectors, starting from Q=1010.
    v4.push_back('{1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 4'b0110});
    v4.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0110});
    v4.push_back('{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b1010});
    v4.push_back('{1'b1, 4'b0101, 1'b1, 1'b1, 1'b0, 4'b1010});
    v4.push_back('{1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 4'b0101});
    v4.push_back('{1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b1010});
    v4.push_back('{1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 4'b0011});

    rst_n = 1'b0;
    drive1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive4(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Reset held: strobed loads must not get through.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if1.enn = (i % 2 == 0);
      @(posedge clk); #1;
      check("reset_hold_w1", {3'b000, if1.Q}, 4'h0);
      check("reset_hold_w4", if4.Q, 4'b1010);
    end

    @(negedge clk);
    rst_n = 1'b1;
    if1.enn = 1'b0;
    @(posedge clk); #1;
    check("post_reset_no_strobe", {3'b000, if1.Q}, 4'h0);
    @(negedge clk);
    if1.enn = 1'b1;
    @(posedge clk); #1;
    check("first_strobe_load", {3'b000, if1.Q}, 4'h1);

    foreach (v1[i]) begin
      @(negedge clk);
      drive1(v1[i].enn, v1[i].d[0], v1[i].ld, v1[i].nld, v1[i].r);
      @(posedge clk); #1;
      check($sformatf("w1_vec%0d", i), {3'b000, if1.Q}, v1[i].exp_q);
    end

    @(negedge clk);
    drive1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    foreach (v4[i]) begin
      @(negedge clk);
      drive4(v4[i].enn, v4[i].d, v4[i].ld, v4[i].nld, v4[i].r);
      @(posedge clk); #1;
      check($sformatf("w4_vec%0d", i), if4.Q, v4[i].exp_q);
    end

    // Slow-period style: strobe once, then hold inputs idle for many cycles.
    @(negedge clk);
    drive1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive4(1'b0, 4'b0011, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (27) @(negedge clk);
    check("slow_period_hold", {3'b000, if1.Q}, 4'h1);

    // Mid-period asynchronous reset overrides a pending load, no clock edge needed.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_w1", {3'b000, if1.Q}, 4'h0);
    check("async_reset_w4", if4.Q, 4'b1010);
    @(negedge clk);
    if1.D = 1'b1; if1.enn = 1'b1;
    @(posedge clk); #1;
    check("reset_blocks_load", {3'b000, if1.Q}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    if1.enn = 1'b0;
    @(posedge clk); #1;
    check("no_state_survives", {3'b000, if1.Q}, 4'h0);
    check("no_state_survives_w4", if4.Q, 4'b1010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
